// File: rtl/mem_read_sequencer.sv
// mem_read_sequencer: decodes a read address to one of three memories, waits per region, returns data on a valid/ready handshake.
// Define MEMSEQ_STATS_EN to add saturating per-region read and error counters.
module mem_read_sequencer #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter logic [ADDR_W-1:0] REGION1_BASE = ADDR_W'(32'h0000_1000),
  parameter logic [ADDR_W-1:0] REGION2_BASE = ADDR_W'(32'h0000_2000),
  parameter logic [ADDR_W-1:0] REGION_END = ADDR_W'(32'h0000_3000),
  parameter int unsigned WAIT_0 = 0,
  parameter int unsigned WAIT_1 = 1,
  parameter int unsigned WAIT_2 = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Req,
  input  logic [ADDR_W-1:0] Address,
  output logic              ReqReady,
  input  logic [DATA_W-1:0] ReadData_1,
  input  logic [DATA_W-1:0] ReadData_2,
  input  logic [DATA_W-1:0] ReadData_3,
  output logic [1:0]        MemorySelector,
  output logic [2:0]        MemEnable,
  output logic [DATA_W-1:0] ReadData,
  output logic              ReadValid,
  output logic              ReadError,
  input  logic              RespReady
`ifdef MEMSEQ_STATS_EN
  ,
  output logic [15:0]       ReadCount_0,
  output logic [15:0]       ReadCount_1,
  output logic [15:0]       ReadCount_2,
  output logic [15:0]       ErrCount
`endif
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state_q;
  logic [3:0] cnt_q;
  logic [3:0] wait_d;
  logic [1:0] sel_d;
  logic [DATA_W-1:0] rdata_d;
  if (WAIT_0 > 15 || WAIT_1 > 15 || WAIT_2 > 15) begin : g_wait_range
    $error("mem_read_sequencer: WAIT_n must fit the 4-bit wait counter (0..15)");
  end
  always_comb begin
    sel_d = Address < REGION1_BASE ? 2'b00 : Address < REGION2_BASE ? 2'b01 : Address < REGION_END ? 2'b10 : 2'b11;
    wait_d = sel_d == 2'b00 ? 4'(WAIT_0) : sel_d == 2'b01 ? 4'(WAIT_1) : 4'(WAIT_2);
    rdata_d = MemorySelector == 2'b00 ? ReadData_1 : MemorySelector == 2'b01 ? ReadData_2 : ReadData_3;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ReqReady <= 1'b1;
      MemorySelector <= 2'b00;
      MemEnable <= 3'b000;
      ReadData <= '0;
      ReadValid <= 1'b0;
      ReadError <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (Req) begin
          MemorySelector <= sel_d;
          cnt_q <= wait_d;
          ReqReady <= 1'b0;
          if (sel_d == 2'b11) begin
            ReadData <= '0;
            ReadError <= 1'b1;
            ReadValid <= 1'b1;
            state_q <= RESP;
          end else begin
            MemEnable <= 3'(1) << sel_d;
            state_q <= ACCESS;
          end
        end
        // Enable stays up through the final counted cycle; data is taken on that same edge.
        ACCESS: if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
        else begin
          MemEnable <= 3'b000;
          ReadData <= rdata_d;
          ReadValid <= 1'b1;
          ReadError <= 1'b0;
          state_q <= RESP;
        end
        RESP: if (RespReady) begin
          ReadValid <= 1'b0;
          ReadError <= 1'b0;
          ReqReady <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef MEMSEQ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {ReadCount_0, ReadCount_1, ReadCount_2, ErrCount} <= '0;
    else if (ReadValid && RespReady) begin
      if (ReadError) ErrCount <= ErrCount + 16'(ErrCount != 16'hFFFF);
      else if (MemorySelector == 2'b00) ReadCount_0 <= ReadCount_0 + 16'(ReadCount_0 != 16'hFFFF);
      else if (MemorySelector == 2'b01) ReadCount_1 <= ReadCount_1 + 16'(ReadCount_1 != 16'hFFFF);
      else ReadCount_2 <= ReadCount_2 + 16'(ReadCount_2 != 16'hFFFF);
    end
  end
`endif
endmodule

// File: tb/tb_mem_read_sequencer.sv
// tb_mem_read_sequencer: table-driven and randomized checks of mem_read_sequencer against a region/wait model.
module tb_mem_read_sequencer;
  logic clk = 0, rst_n = 0, Req = 0, RespReady = 0;
  logic [31:0] Address = 0, ReadData_1 = 0, ReadData_2 = 0, ReadData_3 = 0;
  logic ReqReady, ReadValid, ReadError;
  logic [1:0] MemorySelector;
  logic [2:0] MemEnable;
  logic [31:0] ReadData;
`ifdef MEMSEQ_STATS_EN
  logic [15:0] ReadCount_0, ReadCount_1, ReadCount_2, ErrCount;
`endif
  int checks = 0, failures = 0;

  mem_read_sequencer dut (
    .clk(clk), .rst_n(rst_n), .Req(Req), .Address(Address), .ReqReady(ReqReady),
    .ReadData_1(ReadData_1), .ReadData_2(ReadData_2), .ReadData_3(ReadData_3),
    .MemorySelector(MemorySelector), .MemEnable(MemEnable), .ReadData(ReadData),
    .ReadValid(ReadValid), .ReadError(ReadError), .RespReady(RespReady)
`ifdef MEMSEQ_STATS_EN
    , .ReadCount_0(ReadCount_0), .ReadCount_1(ReadCount_1), .ReadCount_2(ReadCount_2), .ErrCount(ErrCount)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr, d1, d2, d3;
    int hold;
    logic [1:0] sel;
    logic [2:0] en;
    int lat;
    logic [31:0] data;
    logic err;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: region by unsigned address range, wait per region, unmapped answers at once with error.
  function automatic void model(input logic [31:0] a, d1, d2, d3, output logic [1:0] s,
                                output logic [2:0] e, output int lat, output logic [31:0] d, output logic err);
    int r;
    int waits[3] = '{0, 1, 3};
    r = a < 32'h1000 ? 0 : a < 32'h2000 ? 1 : a < 32'h3000 ? 2 : 3;
    s = 2'(r);
    err = (r == 3);
    e = (r == 3) ? 3'b000 : 3'(1 << r);
    lat = (r == 3) ? 1 : waits[r] + 2;
    d = r == 0 ? d1 : r == 1 ? d2 : r == 2 ? d3 : 32'h0;
  endfunction

  task automatic run_txn(input vec_t v);
    int k, en_cnt, bad, unstable;
    k = 0;
    while (!ReqReady && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("ready_before_req", ReqReady, 1);
    Address = v.addr; ReadData_1 = v.d1; ReadData_2 = v.d2; ReadData_3 = v.d3; Req = 1;
    @(negedge clk);
    Req = 0;
    Address = $urandom;
    k = 1; en_cnt = 0; bad = 0;
    while (!ReadValid && k < 40) begin
      if (v.en != 0 && MemEnable == v.en) en_cnt++;
      else if (MemEnable != 0) bad++;
      if (ReqReady) bad++;
      @(negedge clk);
      k++;
    end
    chk("valid_latency", k, v.lat);
    chk("enable_cycles", en_cnt, v.err ? 0 : v.lat - 1);
    chk("enable_or_ready_glitch", bad, 0);
    chk("enable_off_at_valid", MemEnable, 0);
    chk("selector", MemorySelector, v.sel);
    chk("read_data", ReadData, v.data);
    chk("read_error", ReadError, v.err);
    ReadData_1 = $urandom; ReadData_2 = $urandom; ReadData_3 = $urandom;
    unstable = 0;
    for (int i = 0; i < v.hold; i++) begin
      Req = 1'($urandom_range(0, 1));
      Address = $urandom;
      @(negedge clk);
      if (!ReadValid || ReadData !== v.data || ReadError !== v.err || ReqReady || MemEnable != 0
          || MemorySelector !== v.sel) unstable++;
    end
    Req = 0;
    chk("hold_stable", unstable, 0);
    RespReady = 1;
    @(negedge clk);
    RespReady = 0;
    chk("valid_clear", ReadValid, 0);
    chk("error_clear", ReadError, 0);
    chk("ready_after", ReqReady, 1);
    chk("data_kept", ReadData, v.data);
    chk("selector_kept", MemorySelector, v.sel);
  endtask

  task automatic rand_txn(input logic [31:0] a, input int hold);
    vec_t v;
    v.addr = a; v.d1 = $urandom; v.d2 = $urandom; v.d3 = $urandom; v.hold = hold;
    model(v.addr, v.d1, v.d2, v.d3, v.sel, v.en, v.lat, v.data, v.err);
    run_txn(v);
  endtask

  initial begin
    vec_t vecs[8];
    logic [31:0] picks[9] = '{32'h0, 32'h0FFF, 32'h1000, 32'h1FFF, 32'h2000, 32'h2FFF, 32'h3000, 32'hFFFF_FFFF, 32'h0000_2FFC};
    int seen_valid, seen_busy, seen_en;
    vecs[0] = '{32'h0000_0040, 32'hAAAA_0001, 32'h1, 32'h2, 0, 2'b00, 3'b001, 2, 32'hAAAA_0001, 1'b0};
    vecs[1] = '{32'h0000_1FFC, 32'h3, 32'h1234_5678, 32'h4, 4, 2'b01, 3'b010, 3, 32'h1234_5678, 1'b0};
    vecs[2] = '{32'h0000_2000, 32'h5, 32'h6, 32'hDEAD_BEEF, 2, 2'b10, 3'b100, 5, 32'hDEAD_BEEF, 1'b0};
    vecs[3] = '{32'h0000_3000, 32'h7, 32'h8, 32'h9, 1, 2'b11, 3'b000, 1, 32'h0, 1'b1};
    vecs[4] = '{32'h0000_0FFF, 32'h1111_0000, 32'hA, 32'hB, 0, 2'b00, 3'b001, 2, 32'h1111_0000, 1'b0};
    vecs[5] = '{32'h0000_1000, 32'hC, 32'h2222_0000, 32'hD, 1, 2'b01, 3'b010, 3, 32'h2222_0000, 1'b0};
    vecs[6] = '{32'h0000_2FFF, 32'hE, 32'hF, 32'h3333_0000, 0, 2'b10, 3'b100, 5, 32'h3333_0000, 1'b0};
    vecs[7] = '{32'hFFFF_FFFF, 32'h10, 32'h11, 32'h12, 0, 2'b11, 3'b000, 1, 32'h0, 1'b1};

    repeat (2) @(negedge clk);
    chk("rst_req_ready", ReqReady, 1);
    chk("rst_selector", MemorySelector, 0);
    chk("rst_enable", MemEnable, 0);
    chk("rst_data", ReadData, 0);
    chk("rst_valid", ReadValid, 0);
    chk("rst_error", ReadError, 0);
    rst_n = 1;
    @(negedge clk);

    foreach (vecs[i]) run_txn(vecs[i]);

    for (int i = 0; i < 24; i++) begin
      int p = $urandom_range(0, 9);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      rand_txn(p == 9 ? $urandom : picks[p], $urandom_range(0, 3));
    end

    // Asynchronous reset in the second enable cycle of a memory-2 read.
    Address = 32'h0000_2000; ReadData_3 = 32'h5555_AAAA; Req = 1;
    @(negedge clk);
    Req = 0;
    @(negedge clk);
    chk("pre_reset_enable", MemEnable, 3'b100);
    rst_n = 0;
    #1;
    chk("async_rst_enable", MemEnable, 0);
    chk("async_rst_selector", MemorySelector, 0);
    chk("async_rst_valid", ReadValid, 0);
    chk("async_rst_ready", ReqReady, 1);
    chk("async_rst_data", ReadData, 0);
    @(negedge clk);
    rst_n = 1;
    seen_valid = 0; seen_busy = 0; seen_en = 0;
    repeat (8) begin
      @(negedge clk);
      seen_valid += int'(ReadValid);
      seen_busy += int'(!ReqReady);
      seen_en += int'(MemEnable != 0);
    end
    chk("no_valid_after_reset", seen_valid, 0);
    chk("ready_after_reset", seen_busy, 0);
    chk("no_enable_after_reset", seen_en, 0);
    rand_txn(32'h0000_2004, 1);

`ifdef MEMSEQ_STATS_EN
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("stat_rst", {ReadCount_0, ReadCount_1, ReadCount_2, ErrCount}, 0);
    for (int i = 0; i < 3; i++) rand_txn(32'($urandom_range(0, 32'h0FFF)), 0);
    rand_txn(32'h0000_4000, 0);
    chk("stat_rc0", ReadCount_0, 3);
    chk("stat_rc1", ReadCount_1, 0);
    chk("stat_rc2", ReadCount_2, 0);
    chk("stat_err", ErrCount, 1);
    @(negedge clk);
    force dut.ReadCount_0 = 16'hFFFE;
    force dut.ErrCount = 16'hFFFF;
    #1;
    release dut.ReadCount_0;
    release dut.ErrCount;
    for (int i = 0; i < 2; i++) rand_txn(32'h0000_0100, 0);
    rand_txn(32'h0000_5000, 0);
    chk("stat_rc0_sat", ReadCount_0, 16'hFFFF);
    chk("stat_err_sat", ErrCount, 16'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
